ns_responder: RTL

- Synthesizable responder agent for the Needham-Schroeder-Lowe exchange. It is the B-side counterpart to the initiator and network model.
- Consumes encrypted messages from a net-side receive channel and emits message-2 replies on a transmit channel.
- Tracks several concurrent sessions in a slot table, each with its own timeout, and reports commits.
- Sits between the shared message net and any agent or checker that consumes commit events.

---
 rtl/ns_pkg.sv | 42 ++++
 rtl/ns_responder_slot.sv | 86 ++++++++
 rtl/ns_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ns_pkg.sv
// Shared types for the Needham-Schroeder-Lowe responder: slot states, message
// types and the lowest-index picker used for slot allocation and commit lookup.
package ns_pkg;

    localparam int NS_MSB    = 2;
    localparam int ID_W      = NS_MSB + 1;
    localparam int TIMER_W   = 8;
    localparam int MAX_SLOTS = 4;

    typedef enum logic [1:0] {
        SLEEPING  = 2'd0,
        WAITING   = 2'd1,
        COMMITTED = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        M_NoMessage         = 2'd0,
        M_NonceAddress      = 2'd1,
        M_NonceNonceAddress = 2'd2,
        M_Nonce             = 2'd3
    } msg_type_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Lowest set bit wins.
    function automatic pick_t pick_lowest(input logic [MAX_SLOTS-1:0] v);
        pick_t p;
        p.found = 1'b0;
        p.idx   = 2'd0;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                p.found = 1'b1;
                p.idx   = 2'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ns_responder_slot.sv
// One responder session slot: state, partner, nonce and a WAITING timeout.
// The timer is a down-counter loaded on allocation; expiry is at terminal count 0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// SLEEPING  | free, may be allocated by an incoming M_NonceAddress
// WAITING   | reply sent, awaiting M_Nonce with our nonce; times out
// COMMITTED | session completed; terminal until reset
module ns_responder_slot
    import ns_pkg::*;
#(
    parameter int MSB     = NS_MSB,
    parameter int TIMEOUT = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         alloc,
    input  logic [MSB:0] alloc_partner,
    input  logic [MSB:0] alloc_nonce,
    input  logic         commit_hit,
    input  logic [MSB:0] rx_nonce,
    output logic         waiting,
    output logic         sleeping,
    output logic         nonce_match,
    output logic [MSB:0] partner
);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT - 1);

    slot_state_t        state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [MSB:0]       partner_nxt;
    logic [MSB:0]       nonce, nonce_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= SLEEPING;
            timer   <= '0;
            partner <= '0;
            nonce   <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            partner <= partner_nxt;
            nonce   <= nonce_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        partner_nxt = partner;
        nonce_nxt   = nonce;
        unique case (state)
            SLEEPING: begin
                if (alloc) begin
                    state_nxt   = WAITING;
                    timer_nxt   = TIMER_LOAD;
                    partner_nxt = alloc_partner;
                    nonce_nxt   = alloc_nonce;
                end
            end
            WAITING: begin
                // A commit arriving in the expiry cycle still wins.
                if (commit_hit) begin
                    state_nxt = COMMITTED;
                end else if (timer == '0) begin
                    state_nxt = SLEEPING;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            COMMITTED: begin
                state_nxt = COMMITTED;
            end
            default: begin
                state_nxt = SLEEPING;
            end
        endcase
    end

    assign waiting     = (state == WAITING);
    assign sleeping    = (state == SLEEPING);
    assign nonce_match = (nonce == rx_nonce);

endmodule

// File: rtl/ns_responder.sv
// Needham-Schroeder(-Lowe) B-side responder: accepts net messages, allocates
// session slots, emits message-2 replies and reports commits. NS_LOWE_FIX_EN
// puts SELF_ID in the reply address field; otherwise the field is 0.
module ns_responder
    import ns_pkg::*;
#(
    parameter int SELF_ID   = 2,
    parameter int MSB       = NS_MSB,
    parameter int NUM_SLOTS = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [MSB:0] rx_dest,
    input  logic [MSB:0] rx_key,
    input  logic [1:0]   rx_type,
    input  logic [MSB:0] rx_nonce1,
    input  logic [MSB:0] rx_nonce2,
    input  logic [MSB:0] rx_address,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [MSB:0] tx_dest,
    output logic [MSB:0] tx_key,
    output logic [1:0]   tx_type,
    output logic [MSB:0] tx_nonce1,
    output logic [MSB:0] tx_nonce2,
    output logic [MSB:0] tx_address,
    output logic         commit_valid,
    output logic [MSB:0] commit_partner,
    output logic [7:0]   drop_count
);

    localparam logic [MSB:0] SELF = SELF_ID[MSB:0];
`ifdef NS_LOWE_FIX_EN
    localparam logic [MSB:0] REPLY_ADDR = SELF;
`else
    localparam logic [MSB:0] REPLY_ADDR = '0;
`endif

    logic [MAX_SLOTS-1:0] slot_waiting;
    logic [MAX_SLOTS-1:0] slot_sleeping;
    logic [MAX_SLOTS-1:0] slot_match;
    logic [MSB:0]         slot_partner [MAX_SLOTS];

    logic [MSB:0] nonce_ctr;
    pick_t        alloc_pick;
    pick_t        commit_pick;
    logic         accept;
    logic         for_me;
    logic         do_alloc;
    logic         do_commit;
    logic         do_drop;

    // The responder never uses the second nonce of an incoming message.
    logic unused_rx_nonce2;
    assign unused_rx_nonce2 = ^rx_nonce2;

    assign rx_ready = !tx_valid;

    always_comb begin
        accept      = rx_valid && rx_ready;
        for_me      = accept && (rx_dest == SELF);
        alloc_pick  = pick_lowest(slot_sleeping);
        commit_pick = pick_lowest(slot_waiting & slot_match);
        do_alloc    = 1'b0;
        do_commit   = 1'b0;
        do_drop     = 1'b0;
        if (for_me) begin
            if (rx_key != SELF) begin
                do_drop = 1'b1;
            end else if (rx_type == M_NonceAddress) begin
                do_alloc = alloc_pick.found;
                do_drop  = !alloc_pick.found;
            end else if (rx_type == M_Nonce) begin
                do_commit = commit_pick.found;
                do_drop   = !commit_pick.found;
            end else begin
                do_drop = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_slot
        if (g < NUM_SLOTS) begin : g_used
            ns_responder_slot #(
                .MSB     (MSB),
                .TIMEOUT (TIMEOUT)
            ) u_slot (
                .clock         (clock),
                .reset         (reset),
                .alloc         (do_alloc && (alloc_pick.idx == 2'(g))),
                .alloc_partner (rx_address),
                .alloc_nonce   (nonce_ctr),
                .commit_hit    (do_commit && (commit_pick.idx == 2'(g))),
                .rx_nonce      (rx_nonce1),
                .waiting       (slot_waiting[g]),
                .sleeping      (slot_sleeping[g]),
                .nonce_match   (slot_match[g]),
                .partner       (slot_partner[g])
            );
        end else begin : g_unused
            assign slot_waiting[g]  = 1'b0;
            assign slot_sleeping[g] = 1'b0;
            assign slot_match[g]    = 1'b0;
            assign slot_partner[g]  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_valid   <= 1'b0;
            tx_dest    <= '0;
            tx_key     <= '0;
            tx_type    <= '0;
            tx_nonce1  <= '0;
            tx_nonce2  <= '0;
            tx_address <= '0;
        end else if (do_alloc) begin
            tx_valid   <= 1'b1;
            tx_dest    <= rx_address;
            tx_key     <= rx_address;
            tx_type    <= M_NonceNonceAddress;
            tx_nonce1  <= rx_nonce1;
            tx_nonce2  <= nonce_ctr;
            tx_address <= REPLY_ADDR;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            nonce_ctr      <= '0;
            commit_valid   <= 1'b0;
            commit_partner <= '0;
            drop_count     <= '0;
        end else begin
            commit_valid <= do_commit;
            if (do_alloc) begin
                nonce_ctr <= nonce_ctr + 1'b1;
            end
            if (do_commit) begin
                commit_partner <= slot_partner[commit_pick.idx];
            end
            if (do_drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
